// File: rtl/sirv_jtag_master.sv
// JTAG initiator: turns 1..32-bit shift commands into TCK/TMS/TDI waveforms and returns captured TDO.
// Optional TRST pulse support is enabled by defining SIRV_JTAG_MASTER_TRST_EN.
module sirv_jtag_master #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_cmd_valid,
    output logic        io_cmd_ready,
    input  logic [4:0]  io_cmd_bits_len,
    input  logic [31:0] io_cmd_bits_tms,
    input  logic [31:0] io_cmd_bits_tdi,
`ifdef SIRV_JTAG_MASTER_TRST_EN
    input  logic        io_cmd_bits_trst,
    output logic        io_jtag_TRST,
`endif
    output logic        io_rsp_valid,
    input  logic        io_rsp_ready,
    output logic [31:0] io_rsp_bits_tdo,
    output logic        io_jtag_TCK,
    output logic        io_jtag_TMS,
    output logic        io_jtag_TDI,
    input  logic        io_jtag_TDO
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_RESP = 3'd3,
        ST_TRST = 3'd4
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(HALF_DIV - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [4:0]  idx_reg, idx_next;
    logic [4:0]  len_reg, len_next;
    logic [31:0] tms_sh_reg, tms_sh_next;
    logic [31:0] tdi_sh_reg, tdi_sh_next;
    logic [31:0] tdo_reg, tdo_next;
    logic        tms_reg, tms_next;
    logic        tdi_reg, tdi_next;

    logic        cmd_fire;
    logic        timer_done;
    logic        last_bit;
    logic        capture;
    logic        half_reload;
    logic        trst_req;
    logic [4:0]  idx_inc;

`ifdef SIRV_JTAG_MASTER_TRST_EN
    logic [2:0]  trst_cnt_reg, trst_cnt_next;
    assign trst_req = io_cmd_bits_trst;
`else
    assign trst_req = 1'b0;
`endif

    assign cmd_fire   = io_cmd_valid && (state_reg == ST_IDLE);
    assign timer_done = (cnt_reg == 8'd0);
    assign last_bit   = (idx_reg == len_reg);
    assign capture    = (state_reg == ST_LOW) && timer_done;
    assign idx_inc    = idx_reg + 5'd1;

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= CNT_RELOAD;
            idx_reg    <= 5'd0;
            len_reg    <= 5'd0;
            tms_sh_reg <= 32'd0;
            tdi_sh_reg <= 32'd0;
            tdo_reg    <= 32'd0;
            tms_reg    <= 1'b1;
            tdi_reg    <= 1'b0;
`ifdef SIRV_JTAG_MASTER_TRST_EN
            trst_cnt_reg <= 3'd0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            tms_sh_reg <= tms_sh_next;
            tdi_sh_reg <= tdi_sh_next;
            tdo_reg    <= tdo_next;
            tms_reg    <= tms_next;
            tdi_reg    <= tdi_next;
`ifdef SIRV_JTAG_MASTER_TRST_EN
            trst_cnt_reg <= trst_cnt_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cmd_fire) state_next = trst_req ? ST_TRST : ST_LOW;
`ifdef SIRV_JTAG_MASTER_TRST_EN
            ST_TRST: if (timer_done && (trst_cnt_reg == 3'd7)) state_next = ST_LOW;
`endif
            ST_LOW:  if (timer_done) state_next = ST_HIGH;
            ST_HIGH: if (timer_done) state_next = last_bit ? ST_RESP : ST_LOW;
            ST_RESP: if (io_rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // TRST spans eight half-periods, so the half-period timer also reloads inside it
    assign half_reload = (state_next != state_reg) || ((state_reg == ST_TRST) && timer_done);

    always_comb begin
        cnt_next    = half_reload ? CNT_RELOAD : (timer_done ? cnt_reg : cnt_reg - 8'd1);
        idx_next    = idx_reg;
        len_next    = len_reg;
        tms_sh_next = tms_sh_reg;
        tdi_sh_next = tdi_sh_reg;
        tms_next    = tms_reg;
        tdi_next    = tdi_reg;
        if (cmd_fire) begin
            len_next    = io_cmd_bits_len;
            tms_sh_next = io_cmd_bits_tms;
            tdi_sh_next = io_cmd_bits_tdi;
            idx_next    = 5'd0;
            if (!trst_req) begin
                tms_next = io_cmd_bits_tms[0];
                tdi_next = io_cmd_bits_tdi[0];
            end
        end
        if ((state_reg == ST_TRST) && (state_next == ST_LOW)) begin
            tms_next = tms_sh_reg[0];
            tdi_next = tdi_sh_reg[0];
        end
        // TMS/TDI change on the same edge that drops TCK
        if ((state_reg == ST_HIGH) && (state_next == ST_LOW)) begin
            idx_next = idx_inc;
            tms_next = tms_sh_reg[idx_inc];
            tdi_next = tdi_sh_reg[idx_inc];
        end
    end

`ifdef SIRV_JTAG_MASTER_TRST_EN
    always_comb begin
        trst_cnt_next = trst_cnt_reg;
        if (cmd_fire)
            trst_cnt_next = 3'd0;
        else if ((state_reg == ST_TRST) && timer_done)
            trst_cnt_next = trst_cnt_reg + 3'd1;
    end
`endif

    // TDO is sampled directly on the TCK rising edge; a new command clears the whole word
    for (genvar gi = 0; gi < 32; gi++) begin : g_tdo
        assign tdo_next[gi] = cmd_fire ? 1'b0 :
                              (capture && (idx_reg == 5'(gi))) ? io_jtag_TDO : tdo_reg[gi];
    end

    // Output decode
    always_comb begin
        io_cmd_ready    = (state_reg == ST_IDLE);
        io_rsp_valid    = (state_reg == ST_RESP);
        io_jtag_TCK     = (state_reg == ST_HIGH);
        io_jtag_TMS     = tms_reg;
        io_jtag_TDI     = tdi_reg;
        io_rsp_bits_tdo = tdo_reg;
`ifdef SIRV_JTAG_MASTER_TRST_EN
        io_jtag_TRST    = (state_reg == ST_TRST);
`endif
    end

endmodule

// File: tb/tb_sirv_jtag_master.sv
// Directed bench for sirv_jtag_master with HALF_DIV=2; expected values are hand-derived.
module tb_sirv_jtag_master;

    localparam int HD = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_ready;
    logic [4:0]  io_cmd_bits_len = 5'd0;
    logic [31:0] io_cmd_bits_tms = 32'd0;
    logic [31:0] io_cmd_bits_tdi = 32'd0;
`ifdef SIRV_JTAG_MASTER_TRST_EN
    logic        io_cmd_bits_trst = 1'b0;
    logic        io_jtag_TRST;
`endif
    logic        io_rsp_valid;
    logic        io_rsp_ready = 1'b0;
    logic [31:0] io_rsp_bits_tdo;
    logic        io_jtag_TCK;
    logic        io_jtag_TMS;
    logic        io_jtag_TDI;
    logic        io_jtag_TDO;

    logic loop_en = 1'b0;
    logic tdo_tie = 1'b0;
    assign io_jtag_TDO = loop_en ? io_jtag_TDI : tdo_tie;

    sirv_jtag_master #(.HALF_DIV(HD)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_cmd_valid     (io_cmd_valid),
        .io_cmd_ready     (io_cmd_ready),
        .io_cmd_bits_len  (io_cmd_bits_len),
        .io_cmd_bits_tms  (io_cmd_bits_tms),
        .io_cmd_bits_tdi  (io_cmd_bits_tdi),
`ifdef SIRV_JTAG_MASTER_TRST_EN
        .io_cmd_bits_trst (io_cmd_bits_trst),
        .io_jtag_TRST     (io_jtag_TRST),
`endif
        .io_rsp_valid     (io_rsp_valid),
        .io_rsp_ready     (io_rsp_ready),
        .io_rsp_bits_tdo  (io_rsp_bits_tdo),
        .io_jtag_TCK      (io_jtag_TCK),
        .io_jtag_TMS      (io_jtag_TMS),
        .io_jtag_TDI      (io_jtag_TDI),
        .io_jtag_TDO      (io_jtag_TDO)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, rises, highs, trst_highs, trst_tck;
    logic tms_all1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_cmd(input logic [4:0] len, input logic [31:0] tms,
                             input logic [31:0] tdi, input logic trst);
        io_cmd_bits_len = len;
        io_cmd_bits_tms = tms;
        io_cmd_bits_tdi = tdi;
`ifdef SIRV_JTAG_MASTER_TRST_EN
        io_cmd_bits_trst = trst;
`else
        if (trst) $display("note: trst request ignored in this build");
`endif
        io_cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!io_cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("accept_wait", {31'd0, io_cmd_ready}, 32'd1);
        tick();
        io_cmd_valid = 1'b0;
    endtask

    // Called one cycle after the accept edge; counts edges until rsp_valid
    task automatic measure();
        logic prev;
        lat = 0; rises = 0; highs = 0; trst_highs = 0; trst_tck = 0;
        prev = io_jtag_TCK;
        tms_all1 = io_jtag_TMS;
`ifdef SIRV_JTAG_MASTER_TRST_EN
        trst_highs = io_jtag_TRST ? 1 : 0;
`endif
        while (!io_rsp_valid && lat < 2000) begin
            tick();
            lat++;
            if (io_jtag_TCK && !prev) rises++;
            if (io_jtag_TCK) highs++;
            if (!io_jtag_TMS) tms_all1 = 1'b0;
`ifdef SIRV_JTAG_MASTER_TRST_EN
            if (io_jtag_TRST) trst_highs++;
            if (io_jtag_TRST && io_jtag_TCK) trst_tck++;
`endif
            prev = io_jtag_TCK;
        end
    endtask

    task automatic run_cmd(input logic [4:0] len, input logic [31:0] tms,
                           input logic [31:0] tdi, input logic trst);
        drive_cmd(len, tms, tdi, trst);
        wait_accept();
        measure();
        $display("cmd len=%0d tms=%08h tdi=%08h trst=%0d -> tdo=%08h lat=%0d tck_rises=%0d",
                 len, tms, tdi, trst, io_rsp_bits_tdo, lat, rises);
    endtask

    task automatic pop_rsp();
        io_rsp_ready = 1'b1;
        tick();
        io_rsp_ready = 1'b0;
        check_eq("rsp_valid_after_pop", {31'd0, io_rsp_valid}, 32'd0);
    endtask

    initial begin
        int viol;
        logic [31:0] held_tdo;

        // Reset state
        repeat (2) tick();
        check_eq("rst_tck", {31'd0, io_jtag_TCK}, 32'd0);
        check_eq("rst_tms", {31'd0, io_jtag_TMS}, 32'd1);
        check_eq("rst_tdi", {31'd0, io_jtag_TDI}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, io_cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, io_rsp_valid}, 32'd0);
        check_eq("rst_tdo", io_rsp_bits_tdo, 32'd0);
        reset = 1'b0;
        tick();

        // 5 pulses, TMS all ones
        run_cmd(5'd4, 32'h0000_001F, 32'h0, 1'b0);
        check_eq("t2_latency", lat, 32'd20);
        check_eq("t2_tck_rises", rises, 32'd5);
        check_eq("t2_tck_high_cycles", highs, 32'd10);
        check_eq("t2_tms_all_ones", {31'd0, tms_all1}, 32'd1);
        check_eq("t2_cmd_ready_in_resp", {31'd0, io_cmd_ready}, 32'd0);
        pop_rsp();

        // 32-bit loopback
        loop_en = 1'b1;
        run_cmd(5'd31, 32'h0, 32'hA5A5_1234, 1'b0);
        check_eq("t3_tdo", io_rsp_bits_tdo, 32'hA5A5_1234);
        check_eq("t3_latency", lat, 32'd128);
        check_eq("t3_tck_rises", rises, 32'd32);
        check_eq("t3_tdi_held", {31'd0, io_jtag_TDI}, 32'd1);
        check_eq("t3_tms_held", {31'd0, io_jtag_TMS}, 32'd0);
        pop_rsp();

        // Single bit, TDO tied high; upper bits must be cleared
        loop_en = 1'b0;
        tdo_tie = 1'b1;
        run_cmd(5'd0, 32'h0, 32'h1, 1'b0);
        check_eq("t4_tdo", io_rsp_bits_tdo, 32'h0000_0001);
        check_eq("t4_latency", lat, 32'd4);
        check_eq("t4_tck_rises", rises, 32'd1);

        // Backpressure with a second command pending
        loop_en = 1'b1;
        held_tdo = io_rsp_bits_tdo;
        drive_cmd(5'd7, 32'h0, 32'h0000_005A, 1'b0);
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!io_rsp_valid || io_rsp_bits_tdo !== held_tdo || io_cmd_ready) viol++;
        end
        check_eq("t5_hold_violations", viol, 32'd0);
        check_eq("t5_tdo_held", io_rsp_bits_tdo, 32'h0000_0001);
        io_rsp_ready = 1'b1;
        tick();
        io_rsp_ready = 1'b0;
        check_eq("t5_rsp_valid_dropped", {31'd0, io_rsp_valid}, 32'd0);
        check_eq("t5_bubble_ready", {31'd0, io_cmd_ready}, 32'd1);
        tick();
        io_cmd_valid = 1'b0;
        check_eq("t5_accepted_ready", {31'd0, io_cmd_ready}, 32'd0);
        measure();
        $display("cmd len=7 tms=00000000 tdi=0000005a trst=0 -> tdo=%08h lat=%0d tck_rises=%0d",
                 io_rsp_bits_tdo, lat, rises);
        check_eq("t5_tdo", io_rsp_bits_tdo, 32'h0000_005A);
        check_eq("t5_latency", lat, 32'd32);
        pop_rsp();

`ifdef SIRV_JTAG_MASTER_TRST_EN
        // TRST pulse before a single-bit shift
        loop_en = 1'b0;
        tdo_tie = 1'b1;
        run_cmd(5'd0, 32'h0, 32'h1, 1'b1);
        io_cmd_bits_trst = 1'b0;
        check_eq("t6_trst_cycles", trst_highs, 32'(8 * HD));
        check_eq("t6_tck_during_trst", trst_tck, 32'd0);
        check_eq("t6_latency", lat, 32'(10 * HD));
        check_eq("t6_tck_rises", rises, 32'd1);
        check_eq("t6_tdo", io_rsp_bits_tdo, 32'h0000_0001);
        check_eq("t6_trst_low_in_resp", {31'd0, io_jtag_TRST}, 32'd0);
        pop_rsp();
`endif

        // Asynchronous reset in the middle of a shift drops the command
        loop_en = 1'b1;
        drive_cmd(5'd31, 32'h0, 32'hFFFF_FFFF, 1'b0);
        wait_accept();
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("midshift_rst_tck", {31'd0, io_jtag_TCK}, 32'd0);
        check_eq("midshift_rst_tms", {31'd0, io_jtag_TMS}, 32'd1);
        check_eq("midshift_rst_tdi", {31'd0, io_jtag_TDI}, 32'd0);
        check_eq("midshift_rst_ready", {31'd0, io_cmd_ready}, 32'd1);
        #1 reset = 1'b0;
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (io_rsp_valid) viol++;
        end
        check_eq("midshift_no_rsp", viol, 32'd0);

        // Reset while a response is pending
        loop_en = 1'b0;
        tdo_tie = 1'b1;
        run_cmd(5'd0, 32'h0, 32'h1, 1'b0);
        check_eq("t1_rsp_pending", {31'd0, io_rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("t1_rst_rsp_valid", {31'd0, io_rsp_valid}, 32'd0);
        check_eq("t1_rst_cmd_ready", {31'd0, io_cmd_ready}, 32'd1);
        check_eq("t1_rst_tck", {31'd0, io_jtag_TCK}, 32'd0);
        check_eq("t1_rst_tms", {31'd0, io_jtag_TMS}, 32'd1);
        check_eq("t1_rst_tdi", {31'd0, io_jtag_TDI}, 32'd0);
        check_eq("t1_rst_tdo", io_rsp_bits_tdo, 32'd0);
        #1 reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
